// File: rtl/fetch_redirect_stage.sv
// Fetch stage: owns the PC, requests imem over req/ack, fills IF/ID with a one-entry skid.
// Optional FETCH_FLUSH_CNT_EN adds a free-running count of redirect cycles.
module fetch_redirect_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst
`ifdef FETCH_FLUSH_CNT_EN
  ,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD,
    HOLD
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] hold_addr;
  logic [31:0] tgt;
  slot_t       skid;
  logic        skid_valid;
  logic        in_fetch;
  logic        in_hold;
  logic        in_discard;
  logic        blocked;
  logic        ack_ok;
  logic        deliver;
  logic        to_skid;
  logic        from_skid;

  assign tgt        = br_target & ~32'h3;
  assign in_fetch   = (state == FETCH);
  assign in_hold    = (state == HOLD);
  assign in_discard = (state == DISCARD);
  assign blocked    = if_id_valid && stall;
  assign ack_ok     = in_fetch && imem_ack && !br_taken;
  assign deliver    = ack_ok && !blocked;
  assign to_skid    = ack_ok && blocked;
  assign from_skid  = in_hold && !stall && !br_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (br_taken) begin
      if ((in_fetch || in_discard) && !imem_ack)
        state_nx = DISCARD;
      else
        state_nx = FETCH;
    end else begin
      unique case (1'b1)
        (state == IDLE): state_nx = FETCH;
        in_fetch:        state_nx = to_skid ? HOLD : FETCH;
        in_hold:         state_nx = stall ? HOLD : FETCH;
        in_discard:      state_nx = imem_ack ? FETCH : DISCARD;
        default:         state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    unique case (state)
      FETCH:   imem_req = 1'b1;
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = hold_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      if (in_fetch) hold_addr <= pc;
      if (br_taken)    pc <= tgt;
      else if (ack_ok) pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid       <= '0;
    end else if (br_taken) begin
      skid_valid <= 1'b0;
    end else if (to_skid) begin
      skid_valid <= 1'b1;
      skid       <= '{pc: pc, inst: imem_rdata};
    end else if (from_skid) begin
      skid_valid <= 1'b0;
    end
  end

  // Redirect beats stall; stall holds IF/ID otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_inst  <= NOP_INST;
    end else if (br_taken) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (deliver) begin
      if_id_valid <= 1'b1;
      if_id_pc    <= pc;
      if_id_inst  <= imem_rdata;
    end else if (from_skid) begin
      if_id_valid <= skid_valid;
      if_id_pc    <= skid.pc;
      if_id_inst  <= skid_valid ? skid.inst : NOP_INST;
    end else if (!stall) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end
  end

`ifdef FETCH_FLUSH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           flush_count <= '0;
    else if (br_taken) flush_count <= flush_count + 32'd1;
  end
`else
`endif

endmodule

// File: tb/tb_fetch_redirect_stage.sv
// Bench for fetch_redirect_stage: per-cycle vector table plus a reset-in-DISCARD sequence.
// Define FETCH_FLUSH_CNT_EN to also check flush_count.
module tb_fetch_redirect_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
`ifdef FETCH_FLUSH_CNT_EN
  logic [31:0] flush_count;
`endif

  fetch_redirect_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_id_valid(if_id_valid),
    .if_id_pc   (if_id_pc),
    .if_id_inst (if_id_inst)
`ifdef FETCH_FLUSH_CNT_EN
    ,
    .flush_count(flush_count)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h5A00_0003 ^ a;
  endfunction

  assign imem_rdata = mem(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        a;
    logic        er;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_br  = 0;

  function automatic vec_t mk(
    input logic s, input logic b, input logic [31:0] t, input logic a,
    input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t r;
    r.s = s; r.b = b; r.t = t; r.a = a;
    r.er = er; r.ea = ea; r.ev = ev; r.ep = ep;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0;
    br_target = '0; imem_ack = 1'b0;

    vq.push_back(mk(0,0,32'h0,0,        0,32'h0,        0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h0,        1,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h4,        1,32'h4));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h8,        1,32'h8));
    vq.push_back(mk(1,0,32'h0,1,        1,32'hC,        1,32'h8));
    vq.push_back(mk(1,0,32'h0,0,        0,32'h0,        1,32'h8));
    vq.push_back(mk(0,0,32'h0,0,        0,32'h0,        1,32'hC));
    vq.push_back(mk(0,0,32'h0,0,        1,32'h10,       0,32'h0));
    vq.push_back(mk(0,1,32'h103,1,      1,32'h10,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h100,      1,32'h100));
    vq.push_back(mk(0,1,32'h20,1,       1,32'h104,      0,32'h0));
    vq.push_back(mk(0,1,32'h80,0,       1,32'h20,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,0,        1,32'h20,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,0,        1,32'h20,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h20,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h80,       1,32'h80));
    vq.push_back(mk(0,1,32'h200,0,      1,32'h84,       0,32'h0));
    vq.push_back(mk(0,1,32'h300,0,      1,32'h84,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h84,       0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h300,      1,32'h300));
    vq.push_back(mk(1,0,32'h0,1,        1,32'h304,      1,32'h300));
    vq.push_back(mk(1,1,32'h400,0,      0,32'h0,        0,32'h0));
    vq.push_back(mk(1,0,32'h0,1,        1,32'h400,      1,32'h400));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h404,      1,32'h404));
    vq.push_back(mk(0,0,32'h0,0,        1,32'h408,      0,32'h0));
    vq.push_back(mk(0,1,32'hFFFF_FFFF,1,1,32'h408,      0,32'h0));
    vq.push_back(mk(0,0,32'h0,1,        1,32'hFFFF_FFFC,1,32'hFFFF_FFFC));
    vq.push_back(mk(0,0,32'h0,1,        1,32'h0,        1,32'h0));
    vq.push_back(mk(0,1,32'h500,0,      1,32'h4,        0,32'h0));

    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_inst", if_id_inst, NOP);
`ifdef FETCH_FLUSH_CNT_EN
    chk("rst_flush", flush_count, 32'd0);
`endif
    rst = 1'b0;

    foreach (vq[i]) begin
      stall     = vq[i].s;
      br_taken  = vq[i].b;
      br_target = vq[i].t;
      imem_ack  = vq[i].a;
      if (vq[i].b) n_br++;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].er});
      if (vq[i].er) chk($sformatf("v%0d_addr", i), imem_addr, vq[i].ea);
      e.v    = vq[i].ev;
      e.pc   = vq[i].ep;
      e.inst = vq[i].ev ? mem(vq[i].ep) : NOP;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, e.v});
      if (e.v) chk($sformatf("v%0d_pc", i), if_id_pc, e.pc);
      chk($sformatf("v%0d_inst", i), if_id_inst, e.inst);
`ifdef FETCH_FLUSH_CNT_EN
      chk($sformatf("v%0d_flush", i), flush_count, n_br);
`endif
      @(negedge clk);
    end

    stall = 1'b0; br_taken = 1'b0; br_target = '0; imem_ack = 1'b0;
    #1;
    chk("disc_req", {31'd0, imem_req}, 32'd1);
    chk("disc_addr", imem_addr, 32'h4);
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst_pc", if_id_pc, 32'h0);
    chk("arst_inst", if_id_inst, NOP);
`ifdef FETCH_FLUSH_CNT_EN
    chk("arst_flush", flush_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_req", {31'd0, imem_req}, 32'd1);
    chk("post_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("post_valid", {31'd0, if_id_valid}, 32'd1);
    chk("post_pc", if_id_pc, 32'h0);
    chk("post_inst", if_id_inst, mem(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
